serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder stage: captures two operands and a carry-in, then adds them LSB-first,
// one bit per clock, behind a start/busy/done handshake with registered, held results.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic bit_sum;
    logic bit_carry;

    // One-bit full-adder cell fed from the LSBs of the operand shift registers.
    assign bit_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    assign bit_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        shift_d = shift_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = {bit_sum, shift_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = bit_carry;
                if (cnt_q == LAST_BIT) begin
                    // Result registers update only here, with the final bit included.
                    sum_d   = {bit_sum, shift_q[WIDTH-1:1]};
                    cout_d  = bit_carry;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered from the next state so they come straight off flops.
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            shift_q <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            shift_q <= shift_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign sum_out = sum_q;
    assign c_out   = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and swept checks of serial_adder_ctrl at WIDTH=8 and WIDTH=16.
module tb_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start = 1'b0;
    logic [7:0]  a_in = '0, b_in = '0;
    logic        cin = 1'b0;
    logic        busy, done, c_out;
    logic [7:0]  sum_out;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        cin16 = 1'b0;
    logic        busy16, done16, c_out16;
    logic [15:0] sum16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
        .busy(busy), .done(done), .sum_out(sum_out), .c_out(c_out)
    );

    serial_adder_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a_in(a16), .b_in(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum_out(sum16), .c_out(c_out16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One 8-bit operation; "full" adds latency and single-pulse checks.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input string tag, input bit full);
        int n_busy = 0;
        bit got = 0;
        bit stable = 1;
        logic [8:0] held;
        @(negedge clk);
        a_in = a; b_in = b; cin = c; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        held = {c_out, sum_out};
        for (int i = 0; i < 14 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
            else begin
                if (busy) n_busy++;
                if ({c_out, sum_out} !== held) stable = 0;
            end
        end
        check({tag, "_done"}, 64'(got), 64'd1);
        check({tag, "_res"}, 64'({c_out, sum_out}), 64'(a) + 64'(b) + 64'(c));
        check({tag, "_hold"}, 64'(stable), 64'd1);
        if (full) begin
            check({tag, "_busy_cycles"}, 64'(n_busy), 64'd8);
            @(negedge clk);
            check({tag, "_done_one"}, 64'(done), 64'd0);
        end
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c, input string tag);
        bit got = 0;
        bit stable = 1;
        logic [16:0] held;
        @(negedge clk);
        a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
        held = {c_out16, sum16};
        for (int i = 0; i < 22 && !got; i++) begin
            @(negedge clk);
            if (done16) got = 1;
            else if ({c_out16, sum16} !== held) stable = 0;
        end
        check({tag, "_done"}, 64'(got), 64'd1);
        check({tag, "_res"}, 64'({c_out16, sum16}), 64'(a) + 64'(b) + 64'(c));
        check({tag, "_hold"}, 64'(stable), 64'd1);
    endtask

    initial begin
        int n_done;
        int gap;
        bit got;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum_out), 64'd0);
        check("rst_cout", 64'(c_out), 64'd0);
        rst_n = 1'b1;

        // Directed vectors
        op8(8'h5A, 8'h3C, 1'b0, "basic", 1);
        op8(8'hFF, 8'h01, 1'b0, "ovf", 1);
        op8(8'hFF, 8'hFF, 1'b1, "max", 1);

        // start and operand changes during SHIFT are ignored
        @(negedge clk);
        a_in = 8'h5A; b_in = 8'h3C; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a_in = 8'h00; b_in = 8'h00; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 14 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        check("ign_done", 64'(got), 64'd1);
        check("ign_res", 64'({c_out, sum_out}), 64'h096);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("ign_one_pulse", 64'(n_done), 64'd0);

        // Asynchronous reset in the 4th SHIFT cycle
        @(negedge clk);
        a_in = 8'h12; b_in = 8'h34; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_sum", 64'(sum_out), 64'd0);
        check("arst_cout", 64'(c_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("arst_quiet", 64'(n_done), 64'd0);
        op8(8'h80, 8'h80, 1'b1, "post_rst", 1);

        // Continuous start: period WIDTH+2, no acceptance in DONE
        @(negedge clk);
        a_in = 8'h01; b_in = 8'h01; cin = 1'b1; start = 1'b1;
        got = 0;
        for (int i = 0; i < 14 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        check("cont_first_done", 64'(got), 64'd1);
        check("cont_res0", 64'({c_out, sum_out}), 64'h003);
        for (int r = 1; r <= 2; r++) begin
            @(negedge clk);
            check($sformatf("cont_idle%0d", r), 64'({busy, done}), 64'd0);
            gap = 1;
            got = 0;
            for (int i = 0; i < 14 && !got; i++) begin
                @(negedge clk);
                gap++;
                if (done) got = 1;
            end
            if (r == 2) start = 1'b0;
            check($sformatf("cont_gap%0d", r), 64'(gap), 64'd10);
            check($sformatf("cont_res%0d", r), 64'({c_out, sum_out}), 64'h003);
        end
        repeat (3) @(negedge clk);
        check("cont_stopped", 64'(busy), 64'd0);

        // Random sweeps
        for (int i = 0; i < 1000; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd8_%0d", i), 0);
        op16(16'hFFFF, 16'h0001, 1'b0, "w16_ovf");
        op16(16'hFFFF, 16'hFFFF, 1'b1, "w16_max");
        for (int i = 0; i < 1000; i++)
            op16(16'($urandom), 16'($urandom), 1'($urandom), $sformatf("rnd16_%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
